// File: rtl/arm_fetch_prefetch_queue_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
// Req/Addr stay stable from request until the cycle in which Ack completes the transfer.
interface arm_fetch_prefetch_queue_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                 IMEM_Req;
   logic [AddrWidth-1:0] IMEM_Addr;
   logic                 IMEM_Ack;
   logic [DataWidth-1:0] IMEM_Data;

   modport master (output IMEM_Req, IMEM_Addr, input IMEM_Ack, IMEM_Data);
   modport slave  (input IMEM_Req, IMEM_Addr, output IMEM_Ack, IMEM_Data);
endinterface

// File: rtl/arm_fetch_prefetch_queue.sv
// Fetch stage: owns the fetch PC, runs single-outstanding IMEM fetches into a DEPTH-entry queue.
// Head reaches IF/ID one cycle after ack; stall holds the head, flush empties the queue and redirects.
module arm_fetch_prefetch_queue #(
   parameter int                 DEPTH     = 4,
   parameter int                 AddrWidth = 32,
   parameter int                 DataWidth = 32,
   parameter logic [AddrWidth-1:0] RESET_PC = '0
) (
   input  logic                  i_CLK,
   input  logic                  i_NRESET,
   input  logic                  i_STALL,
   input  logic                  i_FLUSH,
   input  logic [AddrWidth-1:0]  i_BranchTarget,
   arm_fetch_prefetch_queue_if.master imem,
   output logic                  o_Valid,
   output logic [DataWidth-1:0]  o_Instr,
   output logic [AddrWidth-1:0]  o_PC,
   output logic [AddrWidth-1:0]  o_PCPlus8
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

   state_e                 state_q, state_d;
   logic                   req_q, req_d;
   logic [AddrWidth-1:0]   fetch_pc_q, fetch_pc_d;
   logic [AddrWidth-1:0]   req_addr_q, req_addr_d;
   logic [CW-1:0]          count_q, count_d, count_nf;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [DataWidth-1:0]   instr_mem_q [DEPTH];
   logic [AddrWidth-1:0]   pc_mem_q    [DEPTH];

   logic                   valid, push, pop;
   logic [AddrWidth-1:0]   target;

   always_comb begin
      target     = i_BranchTarget & ~AddrWidth'(3);
      valid      = (count_q != '0);
      pop        = valid & ~i_STALL & ~i_FLUSH;
      push       = (state_q == REQ) & imem.IMEM_Ack & ~i_FLUSH;
      count_nf   = count_q + CW'(push) - CW'(pop);

      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      count_d    = count_nf;

      unique case (state_q)
         IDLE: begin
            if (i_FLUSH) begin
               fetch_pc_d = target;
               req_addr_d = target;
               state_d    = REQ;
            end else if (count_q < CW'(DEPTH)) begin
               req_addr_d = fetch_pc_q;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (imem.IMEM_Ack && !i_FLUSH) begin
               fetch_pc_d = req_addr_q + AddrWidth'(4);
               if (count_nf < CW'(DEPTH)) req_addr_d = req_addr_q + AddrWidth'(4);
               else                       state_d    = IDLE;
            end else if (imem.IMEM_Ack && i_FLUSH) begin
               fetch_pc_d = target;
               req_addr_d = target;
            end else if (i_FLUSH) begin
               // Address must stay on the stale fetch until memory acks it.
               fetch_pc_d = target;
               state_d    = DROP;
            end
         end
         DROP: begin
            if (imem.IMEM_Ack) begin
               fetch_pc_d = i_FLUSH ? target : fetch_pc_q;
               req_addr_d = i_FLUSH ? target : fetch_pc_q;
               state_d    = REQ;
            end else if (i_FLUSH) begin
               fetch_pc_d = target;
            end
         end
         default: state_d = IDLE;
      endcase

      if (i_FLUSH) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
      req_d = (state_d != IDLE);
   end

   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the queue is empty.
   always_ff @(posedge i_CLK) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem.IMEM_Data;
         pc_mem_q[wr_ptr_q]    <= req_addr_q;
      end
   end

   assign imem.IMEM_Req  = req_q;
   assign imem.IMEM_Addr = req_addr_q;
   assign o_Valid        = valid;
   assign o_Instr        = valid ? instr_mem_q[rd_ptr_q] : '0;
   assign o_PC           = valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign o_PCPlus8      = o_PC + AddrWidth'(8);
endmodule

// File: tb/tb_arm_fetch_prefetch_queue.sv
// Bench for the fetch prefetch queue: directed scenarios plus a scoreboard of acked fetches.
module tb_arm_fetch_prefetch_queue;
   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] target = '0;
   logic        valid;
   logic [31:0] instr, pc, pc8;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        sb[$];
   ent_t        mon_e;
   logic        drop_pend = 1'b0;
   logic [31:0] exp_fetch = '0;
   int          n_chk = 0;
   int          n_fail = 0;

   arm_fetch_prefetch_queue_if #(.AddrWidth(32), .DataWidth(32)) bus ();

   arm_fetch_prefetch_queue #(.DEPTH(4), .AddrWidth(32), .DataWidth(32), .RESET_PC(32'h0)) u_dut (
      .i_CLK          (clk),
      .i_NRESET       (nreset),
      .i_STALL        (stall),
      .i_FLUSH        (flush),
      .i_BranchTarget (target),
      .imem           (bus),
      .o_Valid        (valid),
      .o_Instr        (instr),
      .o_PC           (pc),
      .o_PCPlus8      (pc8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.IMEM_Data = $urandom;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 50 && !bus.IMEM_Req; i++) cyc();
      check("wait_req", bus.IMEM_Req, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   bus.IMEM_Req, 1'b0);
      check({tag, "_addr"},  bus.IMEM_Addr, 32'h0);
      check({tag, "_valid"}, valid, 1'b0);
      check({tag, "_instr"}, instr, 32'h0);
      check({tag, "_pc"},    pc, 32'h0);
      check({tag, "_pc8"},   pc8, 32'h8);
   endtask

   // Reference model: which upcoming edge pushes/pops/flushes, evaluated mid-cycle.
   always @(negedge clk) begin
      if (!nreset) begin
         sb.delete();
         drop_pend = 1'b0;
         exp_fetch = 32'h0;
      end else begin
         check("valid", valid, sb.size() != 0);
         if (sb.size() == 0) begin
            check("empty_instr", instr, 32'h0);
            check("empty_pc", pc, 32'h0);
         end
         if (valid && !stall && !flush && sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("pop_instr", instr, mon_e.instr);
            check("pop_pc", pc, mon_e.pc);
            check("pop_pc8", pc8, mon_e.pc + 32'd8);
         end
         if (bus.IMEM_Req && bus.IMEM_Ack) begin
            if (drop_pend) begin
               drop_pend = 1'b0;
            end else if (!flush) begin
               check("imem_addr", bus.IMEM_Addr, exp_fetch);
               sb.push_back({bus.IMEM_Data, exp_fetch});
               exp_fetch = exp_fetch + 32'd4;
            end
         end else if (bus.IMEM_Req && flush) begin
            drop_pend = 1'b1;
         end
         if (flush) begin
            sb.delete();
            exp_fetch = target & ~32'd3;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit %0d", 200000);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.IMEM_Ack  = 1'b1;
      bus.IMEM_Data = 32'h0;
      stall         = 1'b1;
      #12;
      check_reset_outputs("rst");

      // T1: ack held, queue fills back-to-back while stalled
      cyc();
      nreset = 1'b1;
      cyc();
      check("t1_req", bus.IMEM_Req, 1'b1);
      check("t1_addr0", bus.IMEM_Addr, 32'h0);
      cyc(); check("t1_addr4", bus.IMEM_Addr, 32'h4);
      cyc(); check("t1_addr8", bus.IMEM_Addr, 32'h8);
      cyc(); check("t1_addrc", bus.IMEM_Addr, 32'hC);
      cyc();
      check("t1_full_req", bus.IMEM_Req, 1'b0);
      check("t1_valid", valid, 1'b1);
      check("t1_pc", pc, 32'h0);
      check("t1_pc8", pc8, 32'h8);

      // T2: stall holds the full queue, release resumes fetching
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("t2_hold_pc", pc, 32'h0);
         check("t2_hold_instr", instr, sb[0].instr);
         check("t2_hold_req", bus.IMEM_Req, 1'b0);
      end
      stall = 1'b0;
      cyc();
      check("t2_req_lag", bus.IMEM_Req, 1'b0);
      cyc();
      check("t2_req_resume", bus.IMEM_Req, 1'b1);
      for (int i = 0; i < 20; i++) begin
         bus.IMEM_Ack = 1'($urandom_range(0, 1));
         stall        = 1'($urandom_range(0, 1));
         cyc();
      end

      // T3: flush coinciding with ack
      stall = 1'b0;
      bus.IMEM_Ack = 1'b1;
      wait_req();
      flush  = 1'b1;
      target = 32'h104;
      cyc();
      flush = 1'b0;
      bus.IMEM_Ack = 1'b0;
      check("t3_valid", valid, 1'b0);
      check("t3_addr", bus.IMEM_Addr, 32'h104);
      check("t3_req", bus.IMEM_Req, 1'b1);

      // T4: flush while request pending, stale ack discarded
      flush  = 1'b1;
      target = 32'h200;
      cyc();
      flush = 1'b0;
      check("t4_addr_hold0", bus.IMEM_Addr, 32'h104);
      check("t4_req_hold", bus.IMEM_Req, 1'b1);
      cyc();
      cyc();
      check("t4_addr_hold2", bus.IMEM_Addr, 32'h104);
      bus.IMEM_Ack  = 1'b1;
      bus.IMEM_Data = 32'hDEAD;
      cyc();
      bus.IMEM_Ack = 1'b0;
      check("t4_addr_redirect", bus.IMEM_Addr, 32'h200);
      check("t4_valid_drop", valid, 1'b0);
      cyc();
      check("t4_valid_drop2", valid, 1'b0);
      flush  = 1'b1;
      target = 32'h280;
      cyc();
      target = 32'h300;
      cyc();
      flush = 1'b0;
      check("t4_addr_stale", bus.IMEM_Addr, 32'h200);
      bus.IMEM_Ack = 1'b1;
      cyc();
      bus.IMEM_Ack = 1'b0;
      check("t4_addr_second", bus.IMEM_Addr, 32'h300);

      // T5: target alignment and PC wrap
      stall  = 1'b1;
      flush  = 1'b1;
      target = 32'h203;
      cyc();
      flush = 1'b0;
      bus.IMEM_Ack = 1'b1;
      cyc();
      bus.IMEM_Ack = 1'b0;
      check("t5_align", bus.IMEM_Addr, 32'h200);
      flush  = 1'b1;
      target = 32'hFFFF_FFFC;
      bus.IMEM_Ack = 1'b1;
      cyc();
      flush = 1'b0;
      check("t5_addr_top", bus.IMEM_Addr, 32'hFFFF_FFFC);
      check("t5_valid0", valid, 1'b0);
      cyc();
      bus.IMEM_Ack = 1'b0;
      check("t5_addr_wrap", bus.IMEM_Addr, 32'h0);
      check("t5_valid1", valid, 1'b1);
      check("t5_pc", pc, 32'hFFFF_FFFC);
      check("t5_pc8_wrap", pc8, 32'h4);

      // T6: reset mid-request, acks during reset ignored
      bus.IMEM_Ack = 1'b1;
      cyc();
      bus.IMEM_Ack = 1'b0;
      check("t6_pre_addr", bus.IMEM_Addr, 32'h4);
      nreset = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      bus.IMEM_Ack = 1'b1;
      cyc();
      cyc();
      check_reset_outputs("t6_held");
      nreset = 1'b1;
      cyc();
      check("t6_valid", valid, 1'b0);
      check("t6_req", bus.IMEM_Req, 1'b1);
      check("t6_addr", bus.IMEM_Addr, 32'h0);
      bus.IMEM_Ack = 1'b0;
      cyc();
      check("t6_valid_late", valid, 1'b0);

      // Mixed traffic with occasional redirects
      for (int i = 0; i < 200; i++) begin
         bus.IMEM_Ack = 1'($urandom_range(0, 1));
         stall        = 1'($urandom_range(0, 3) == 0);
         flush        = 1'($urandom_range(0, 9) == 0);
         target       = $urandom;
         cyc();
      end
      flush = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
